brick_game_state: RTL and testbench

//  Game-state engine that produces the brick/paddle geometry and win/lose flags read by the pixel colour mapper.

---
 rtl/brick_game_state_pkg.sv | 35 +++
 rtl/brick_game_state_if.sv | 35 +++
 rtl/brick_game_state_hit_test.sv | 37 +++
 rtl/brick_game_state.sv | 176 +++++++++++++++++
 tb/tb_brick_game_state.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/brick_game_state_pkg.sv
// Shared types, playfield geometry and brick placement helpers for the brick game engine.
package brick_game_state_pkg;

  localparam int COORD_W       = 10;
  localparam int NUM_BRICKS    = 9;
  localparam int BRICK_COLS    = 3;
  localparam int BRICK_X0      = 100;
  localparam int BRICK_PITCH_X = 160;
  localparam int BRICK_Y0      = 40;
  localparam int BRICK_PITCH_Y = 40;
  localparam int BRICK_W       = 60;
  localparam int BRICK_H       = 20;
  localparam int PADDLE_Y      = 440;
  localparam int PADDLE_H      = 8;
  localparam int LOSE_Y        = 470;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    PLAY,
    SCAN,
    REPORT,
    WON,
    LOST
  } state_t;

  function automatic coord_t brick_x(input int i);
    return coord_t'(BRICK_X0 + (i % BRICK_COLS) * BRICK_PITCH_X);
  endfunction

  function automatic coord_t brick_y(input int i);
    return coord_t'(BRICK_Y0 + (i / BRICK_COLS) * BRICK_PITCH_Y);
  endfunction

endpackage

// File: rtl/brick_game_state_if.sv
// Ball/paddle inputs and brick geometry, bounce and win/lose outputs of the game-state engine.
interface brick_game_state_if;
  import brick_game_state_pkg::*;

  logic                          frame_clk;
  logic                          restart;
  coord_t                        BallX;
  coord_t                        BallY;
  coord_t                        Ball_size;
  coord_t                        PaddleX;
  logic [NUM_BRICKS-1:0]         brick_exists;
  logic [(NUM_BRICKS+1)*COORD_W-1:0] brick_x_vals;
  logic [(NUM_BRICKS+1)*COORD_W-1:0] brick_y_vals;
  coord_t                        brick_width;
  coord_t                        brick_height;
  coord_t                        paddle_height;
  logic                          bounce_x;
  logic                          bounce_y;
  logic [3:0]                    bricks_left;
  logic                          did_win_game;
  logic                          did_lose_game;

  modport master (
    output frame_clk, restart, BallX, BallY, Ball_size, PaddleX,
    input  brick_exists, brick_x_vals, brick_y_vals, brick_width, brick_height,
           paddle_height, bounce_x, bounce_y, bricks_left, did_win_game, did_lose_game
  );

  modport slave (
    input  frame_clk, restart, BallX, BallY, Ball_size, PaddleX,
    output brick_exists, brick_x_vals, brick_y_vals, brick_width, brick_height,
           paddle_height, bounce_x, bounce_y, bricks_left, did_win_game, did_lose_game
  );

endinterface

// File: rtl/brick_game_state_hit_test.sv
// Ball-versus-rectangle overlap test, ball treated as a square of half-width ball_size.
// Latency: combinational.
// Backpressure: none.
module brick_game_state_hit_test
  import brick_game_state_pkg::*;
(
  input  coord_t ball_x,
  input  coord_t ball_y,
  input  coord_t ball_size,
  input  coord_t brick_x,
  input  coord_t brick_y,
  input  coord_t width,
  input  coord_t height,
  output logic   hit,
  output logic   hit_is_vertical
);

  typedef logic [COORD_W:0] wide_t;

  wide_t x_w, y_w, r_w, bx_w, by_w, x_right, y_bottom;

  // One extra bit keeps every sum from wrapping at the screen edge.
  always_comb begin
    x_w      = {1'b0, ball_x};
    y_w      = {1'b0, ball_y};
    r_w      = {1'b0, ball_size};
    bx_w     = {1'b0, brick_x};
    by_w     = {1'b0, brick_y};
    x_right  = bx_w + {1'b0, width} - wide_t'(1);
    y_bottom = by_w + {1'b0, height} - wide_t'(1);

    hit = (x_w + r_w >= bx_w) && (x_w <= x_right + r_w) &&
          (y_w + r_w >= by_w) && (y_w <= y_bottom + r_w);
    hit_is_vertical = (x_w >= bx_w) && (x_w <= x_right);
  end

endmodule

// File: rtl/brick_game_state.sv
// Per-frame brick collision scan, brick removal, bounce requests and win/lose tracking.
// Latency: frame_clk rise to bounce pulse is 14 Clk (3 sync/edge + 1 latch + 9 scan + 1 report).
// Backpressure: none; frame edges arriving outside PLAY are dropped.
module brick_game_state
  import brick_game_state_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  brick_game_state_if.slave bus
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_BRICKS - 1);
  localparam logic [3:0] ALL_LEFT = 4'(NUM_BRICKS);
  localparam coord_t     LOSE_LINE = coord_t'(LOSE_Y);

  state_t                state, state_nxt;
  logic [2:0]            frame_sync;
  logic                  frame_edge;
  coord_t                ball_x_q, ball_y_q, ball_size_q;
  logic [3:0]            idx;
  logic [NUM_BRICKS-1:0] exists;
  logic [3:0]            left;
  logic                  hit_done, rec_x, rec_y;
  logic                  bounce_x_q, bounce_y_q, won_q, lost_q;
  logic                  enter_won, enter_lost, restore;
  coord_t                cur_bx, cur_by;
  logic                  raw_hit, hit_vert, hit_now;
  logic [(NUM_BRICKS+1)*COORD_W-1:0] x_vals, y_vals;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_sync <= '0;
      frame_edge <= 1'b0;
    end else begin
      frame_sync <= {frame_sync[1:0], bus.frame_clk};
      frame_edge <= frame_sync[1] & ~frame_sync[2];
    end
  end

  always_comb begin
    cur_bx = '0;
    cur_by = '0;
    for (int i = 0; i < NUM_BRICKS; i++) begin
      if (idx == 4'(i)) begin
        cur_bx = brick_x(i);
        cur_by = brick_y(i);
      end
    end
  end

  brick_game_state_hit_test u_hit (
    .ball_x          (ball_x_q),
    .ball_y          (ball_y_q),
    .ball_size       (ball_size_q),
    .brick_x         (cur_bx),
    .brick_y         (cur_by),
    .width           (coord_t'(BRICK_W)),
    .height          (coord_t'(BRICK_H)),
    .hit             (raw_hit),
    .hit_is_vertical (hit_vert)
  );

  assign hit_now = raw_hit && exists[idx] && !hit_done;

  always_ff @(posedge Clk) begin
    if (Reset) state <= PLAY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    enter_won  = 1'b0;
    enter_lost = 1'b0;
    restore    = 1'b0;
    case (state)
      PLAY:   if (frame_edge) state_nxt = SCAN;
      SCAN:   if (idx == LAST_IDX) state_nxt = REPORT;
      REPORT: begin
        // Clearing the last brick wins even if the ball also crossed the loss line.
        if (exists == '0) begin
          enter_won = 1'b1;
          state_nxt = WON;
        end else if (ball_y_q >= LOSE_LINE) begin
          enter_lost = 1'b1;
          state_nxt  = LOST;
        end else begin
          state_nxt = PLAY;
        end
      end
      WON, LOST: begin
        if (bus.restart) begin
          restore   = 1'b1;
          state_nxt = PLAY;
        end
      end
      default: state_nxt = PLAY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ball_x_q    <= '0;
      ball_y_q    <= '0;
      ball_size_q <= '0;
      idx         <= '0;
      exists      <= '1;
      left        <= ALL_LEFT;
      hit_done    <= 1'b0;
      rec_x       <= 1'b0;
      rec_y       <= 1'b0;
      bounce_x_q  <= 1'b0;
      bounce_y_q  <= 1'b0;
      won_q       <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      bounce_x_q <= 1'b0;
      bounce_y_q <= 1'b0;
      if (state == PLAY && frame_edge) begin
        ball_x_q    <= bus.BallX;
        ball_y_q    <= bus.BallY;
        ball_size_q <= bus.Ball_size;
        idx         <= '0;
        hit_done    <= 1'b0;
        rec_x       <= 1'b0;
        rec_y       <= 1'b0;
      end
      if (state == SCAN) begin
        if (hit_now) begin
          exists[idx] <= 1'b0;
          left        <= left - 4'd1;
          hit_done    <= 1'b1;
          rec_y       <= hit_vert;
          rec_x       <= ~hit_vert;
        end
        if (idx != LAST_IDX) idx <= idx + 4'd1;
      end
      if (state == REPORT) begin
        bounce_x_q <= rec_x;
        bounce_y_q <= rec_y;
      end
      if (enter_won)  won_q  <= 1'b1;
      if (enter_lost) lost_q <= 1'b1;
      if (restore) begin
        exists <= '1;
        left   <= ALL_LEFT;
        won_q  <= 1'b0;
        lost_q <= 1'b0;
      end
    end
  end

  // Slot NUM_BRICKS carries the paddle so the colour mapper sees one uniform table.
  always_comb begin
    x_vals = '0;
    y_vals = '0;
    for (int i = 0; i < NUM_BRICKS; i++) begin
      x_vals[i*COORD_W +: COORD_W] = brick_x(i);
      y_vals[i*COORD_W +: COORD_W] = brick_y(i);
    end
    x_vals[NUM_BRICKS*COORD_W +: COORD_W] = bus.PaddleX;
    y_vals[NUM_BRICKS*COORD_W +: COORD_W] = coord_t'(PADDLE_Y);
  end

  assign bus.brick_x_vals  = x_vals;
  assign bus.brick_y_vals  = y_vals;
  assign bus.brick_width   = coord_t'(BRICK_W);
  assign bus.brick_height  = coord_t'(BRICK_H);
  assign bus.paddle_height = coord_t'(PADDLE_H);
  assign bus.brick_exists  = exists;
  assign bus.bricks_left   = left;
  assign bus.bounce_x      = bounce_x_q;
  assign bus.bounce_y      = bounce_y_q;
  assign bus.did_win_game  = won_q;
  assign bus.did_lose_game = lost_q;

endmodule

// File: tb/tb_brick_game_state.sv
// Directed frames against a brick-list model of the game; bounce and state outputs checked every cycle.
module tb_brick_game_state;
  import brick_game_state_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  brick_game_state_if bus();
  brick_game_state dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Model of the game
  logic [8:0] m_exists;
  int         m_left;
  bit         m_won, m_lost;
  int         pulse_cyc = -1;
  bit         pulse_x, pulse_y;
  bit         settled = 0;
  int         cnt_bx = 0, cnt_by = 0;

  task automatic check(input string name, input logic [99:0] act, input logic [99:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_hit(input int i, input int x, input int y, input int r);
    int bx, by;
    bx = 100 + (i % 3) * 160;
    by = 40 + (i / 3) * 40;
    return m_exists[i] && (x + r >= bx) && (x <= bx + 59 + r) &&
           (y + r >= by) && (y <= by + 19 + r);
  endfunction

  task automatic model_reset();
    m_exists = 9'h1FF;
    m_left   = 9;
    m_won    = 0;
    m_lost   = 0;
  endtask

  always @(negedge Clk) begin
    if (bus.bounce_x === 1'b1) cnt_bx++;
    if (bus.bounce_y === 1'b1) cnt_by++;
  end

  always @(negedge Clk) begin
    check("bounce_x", bus.bounce_x, (cyc == pulse_cyc) && pulse_x);
    check("bounce_y", bus.bounce_y, (cyc == pulse_cyc) && pulse_y);
    if (settled) begin
      check("brick_exists", bus.brick_exists, m_exists);
      check("bricks_left", bus.bricks_left, m_left);
      check("did_win_game", bus.did_win_game, m_won);
      check("did_lose_game", bus.did_lose_game, m_lost);
    end
  end

  task automatic frame(input int x, input int y, input int r);
    int t0, hit_i, bx;
    hit_i = -1;
    @(negedge Clk);
    bus.BallX = coord_t'(x);
    bus.BallY = coord_t'(y);
    bus.Ball_size = coord_t'(r);
    bus.frame_clk = 1'b1;
    t0 = cyc;
    settled = 0;
    pulse_cyc = -1;
    if (!m_won && !m_lost) begin
      for (int i = 0; i < 9; i++)
        if (hit_i < 0 && m_hit(i, x, y, r)) hit_i = i;
      if (hit_i >= 0) begin
        bx = 100 + (hit_i % 3) * 160;
        pulse_y = (x >= bx) && (x <= bx + 59);
        pulse_x = !pulse_y;
        pulse_cyc = t0 + 14;
      end
    end
    repeat (4) @(negedge Clk);
    bus.frame_clk = 1'b0;
    repeat (12) @(negedge Clk);
    if (!m_won && !m_lost) begin
      if (hit_i >= 0) begin
        m_exists[hit_i] = 1'b0;
        m_left--;
      end
      if (m_exists == 9'h0) m_won = 1;
      else if (y >= 470) m_lost = 1;
    end
    settled = 1;
  endtask

  task automatic do_restart();
    @(negedge Clk);
    settled = 0;
    bus.restart = 1'b1;
    @(negedge Clk);
    bus.restart = 1'b0;
    if (m_won || m_lost) model_reset();
    settled = 1;
  endtask

  initial begin
    int t0;
    Reset = 1'b1;
    bus.frame_clk = 1'b0;
    bus.restart = 1'b0;
    bus.BallX = '0;
    bus.BallY = '0;
    bus.Ball_size = '0;
    bus.PaddleX = 10'd321;
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    settled = 1;
    @(negedge Clk);

    check("rst_exists", bus.brick_exists, 9'h1FF);
    check("rst_left", bus.bricks_left, 4'd9);
    check("rst_flags", {bus.did_win_game, bus.did_lose_game}, 2'b00);
    check("slot0_x", bus.brick_x_vals[9:0], 10'd100);
    check("slot0_y", bus.brick_y_vals[9:0], 10'd40);
    check("slot4_x", bus.brick_x_vals[49:40], 10'd260);
    check("slot4_y", bus.brick_y_vals[49:40], 10'd80);
    check("slot9_x", bus.brick_x_vals[99:90], 10'd321);
    check("slot9_y", bus.brick_y_vals[99:90], 10'd440);
    check("dims", {bus.brick_width, bus.brick_height, bus.paddle_height},
          {10'd60, 10'd20, 10'd8});
    bus.PaddleX = 10'd77;
    #1 check("slot9_x_follow", bus.brick_x_vals[99:90], 10'd77);

    frame(130, 62, 4);
    check("t2_exists", bus.brick_exists, 9'h1FE);
    check("t2_left", bus.bricks_left, 4'd8);
    check("t2_pulses", {8'(cnt_bx), 8'(cnt_by)}, {8'd0, 8'd1});

    frame(258, 90, 4);
    check("t3_exists", bus.brick_exists, 9'h1EE);
    check("t3_pulses", {8'(cnt_bx), 8'(cnt_by)}, {8'd1, 8'd1});
    frame(258, 90, 4);
    check("t3_repeat_pulses", {8'(cnt_bx), 8'(cnt_by)}, {8'd1, 8'd1});

    do_restart();
    check("restart_in_play", bus.brick_exists, 9'h1EE);

    frame(370, 50, 60);
    check("t4_exists", bus.brick_exists, 9'h1EC);
    check("t4_left", bus.bricks_left, 4'd6);

    frame(450, 50, 4);
    frame(130, 90, 4);
    frame(450, 90, 4);
    frame(130, 130, 4);
    frame(290, 130, 4);
    frame(450, 475, 400);
    check("t5_exists", bus.brick_exists, 9'h000);
    check("t5_flags", {bus.did_win_game, bus.did_lose_game}, 2'b10);
    frame(130, 62, 4);
    check("t5_ignored", {bus.did_win_game, 8'(cnt_bx + cnt_by)}, {1'b1, 8'd9});

    do_restart();
    check("t6_restart_won", {bus.brick_exists, bus.bricks_left}, {9'h1FF, 4'd9});
    frame(10, 470, 4);
    check("t6_lost", {bus.did_win_game, bus.did_lose_game}, 2'b01);
    frame(130, 62, 4);
    check("t6_lost_ignored", bus.brick_exists, 9'h1FF);
    do_restart();
    check("t6_restart_lost", {bus.did_win_game, bus.did_lose_game, bus.brick_exists},
          {2'b00, 9'h1FF});

    // Reset lands while the scan is running and brick 0 has just been hit.
    @(negedge Clk);
    bus.BallX = 10'd130;
    bus.BallY = 10'd62;
    bus.Ball_size = 10'd4;
    bus.frame_clk = 1'b1;
    t0 = cyc;
    settled = 0;
    pulse_cyc = -1;
    repeat (4) @(negedge Clk);
    bus.frame_clk = 1'b0;
    repeat (5) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    settled = 1;
    repeat (12) @(negedge Clk);
    check("rst_mid_scan", {bus.brick_exists, bus.bricks_left, 8'(cnt_bx + cnt_by)},
          {9'h1FF, 4'd9, 8'd9});
    check("rst_mid_scan_span", cyc - t0 >= 20, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
